// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: source indices and load funct3 codes.
package wb_pkg;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MEM = 1;
    localparam int WB_SRC_PC4 = 2;
    localparam int WB_SRC_IMM = 3;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational sub-word load extraction (byte/half, signed/unsigned) with misalignment detect.
module load_extend
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] ext_data,
    output logic              misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = data[{offset, 3'b000} +: 8];
    assign half_sel = offset[1] ? data[31:16] : data[15:0];

    always_comb begin
        ext_data = data;
        misalign = 1'b0;
        case (funct3)
            LD_LB:  ext_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_LBU: ext_data = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_LH: begin
                ext_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
                misalign = offset[0];
            end
            LD_LHU: begin
                ext_data = {{(DATA_W-16){1'b0}}, half_sel};
                misalign = offset[0];
            end
            LD_LW:  misalign = (offset != 2'b00);
            default: ext_data = data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Registered writeback stage: source select, optional load extension, retire counter, sticky errors.
// Optional feature macro: WB_LOAD_EXT_EN (sub-word load extraction on the memory source).
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_SRC    = 4,
    parameter int MEM_SRC    = WB_SRC_MEM,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      stall,
    input  logic [SEL_W-1:0]          wb_sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [REG_ADDR_W-1:0]     rd_addr,
    input  logic                      reg_write,
    input  logic [2:0]                ld_funct3,
    input  logic [1:0]                ld_offset,
    output logic                      out_valid,
    output logic                      wb_we,
    output logic [REG_ADDR_W-1:0]     wb_rd,
    output logic [DATA_W-1:0]         wb_data,
    output logic [CNT_W-1:0]          retire_cnt,
    output logic                      sel_err,
    output logic                      align_err
);

    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] wb_value;
    logic              sel_bad;
    logic              align_now;
    logic              reg_write_q;
    logic              accept;

    assign in_ready = ~stall;
    assign accept   = in_valid & ~stall;
    assign sel_bad  = (32'(wb_sel) >= 32'(NUM_SRC));

    // Out-of-range selects fall back to source 0.
    always_comb begin
        sel_data = src_data[DATA_W-1:0];
        for (int i = 1; i < NUM_SRC; i++)
            if (32'(wb_sel) == 32'(i))
                sel_data = src_data[i*DATA_W +: DATA_W];
    end

`ifdef WB_LOAD_EXT_EN
    logic [DATA_W-1:0] ld_data;
    logic              ld_misalign;
    logic              is_mem;

    assign is_mem = (32'(wb_sel) == 32'(MEM_SRC));

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .data     (sel_data),
        .funct3   (ld_funct3),
        .offset   (ld_offset),
        .ext_data (ld_data),
        .misalign (ld_misalign)
    );

    assign wb_value  = is_mem ? ld_data : sel_data;
    assign align_now = is_mem & ld_misalign;
`else
    logic unused_ld;
    assign unused_ld = ^{ld_funct3, ld_offset};
    assign wb_value  = sel_data;
    assign align_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            reg_write_q <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            retire_cnt  <= '0;
            sel_err     <= 1'b0;
            align_err   <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            if (accept) begin
                wb_data     <= wb_value;
                wb_rd       <= rd_addr;
                reg_write_q <= reg_write;
                retire_cnt  <= retire_cnt + 1'b1;
                if (sel_bad)   sel_err   <= 1'b1;
                if (align_now) align_err <= 1'b1;
            end
        end
    end

    // Consumer must also gate with ~stall to avoid rewriting a held instruction.
    assign wb_we = out_valid & reg_write_q & (wb_rd != '0);

endmodule
